// File: rtl/exec_output_arbiter.sv
// Round-robin arbiter collecting results from four execution units into a
// single registered slot handed to the memory stage.
module exec_output_arbiter #(
  parameter int ROBsize    = 16,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [3:0]                 valid_i,
  input  logic [3:0][63:0]           executeVal_i,
  input  logic [3:0][9:0]            executeCommands_i,
  input  logic [3:0][ROBsizeLog-1:0] executeTag_i,
  input  logic [3:0][3:0]            executeFlags_i,
  output logic [3:0]                 canGo_o,
  input  logic                       memReady_i,
  input  logic                       flush_i,
  output logic [63:0]                dataToMem_o,
  output logic [9:0]                 commandsToMem_o,
  output logic [ROBsizeLog-1:0]      tagToMem_o,
  output logic [3:0]                 flagsToMem_o,
  output logic                       valid_o
);

  logic                  valid_q, valid_d;
  logic [63:0]           data_q, data_d;
  logic [9:0]            cmd_q, cmd_d;
  logic [ROBsizeLog-1:0] tag_q, tag_d;
  logic [3:0]            flags_q, flags_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;

  logic                  reg_free;
  logic                  grant_any;
  logic [1:0]            grant_idx;
  logic [3:0]            grant;

  // Grant search: walking from the farthest candidate back to rr_ptr lets the
  // nearest requesting unit win without a priority chain written out by hand.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_idx = rr_ptr_q;
    grant_any = 1'b0;
    reg_free  = !valid_q || memReady_i;
    if (reset_i && !flush_i && reg_free) begin
      for (int k = 3; k >= 0; k--) begin
        idx = rr_ptr_q + 2'(k);
        if (valid_i[idx]) begin
          grant_idx = idx;
          grant_any = 1'b1;
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  assign canGo_o = grant;

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    cmd_d    = cmd_q;
    tag_d    = tag_q;
    flags_d  = flags_q;
    rr_ptr_d = rr_ptr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (grant_any) begin
      valid_d  = 1'b1;
      data_d   = executeVal_i[grant_idx];
      cmd_d    = executeCommands_i[grant_idx];
      tag_d    = executeTag_i[grant_idx];
      flags_d  = executeFlags_i[grant_idx];
      rr_ptr_d = grant_idx + 2'd1;
    end else if (memReady_i) begin
      // Drained with nothing to replace it: data fields keep their last value.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      cmd_q    <= '0;
      tag_q    <= '0;
      flags_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      cmd_q    <= cmd_d;
      tag_q    <= tag_d;
      flags_q  <= flags_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign valid_o         = valid_q;
  assign dataToMem_o     = data_q;
  assign commandsToMem_o = cmd_q;
  assign tagToMem_o      = tag_q;
  assign flagsToMem_o    = flags_q;

endmodule
